// File: rtl/pipe_pkg.sv
// Shared encodings for elastic pipeline blocks: stage state codes and occupancy width.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Illegal codes report zero entries; the FSM steers them back to ST_EMPTY.
  function automatic logic [OCC_W-1:0] occ_of(input logic [1:0] st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (st)
      ST_BUSY: occ = OCC_W'(1);
      ST_FULL: occ = OCC_W'(2);
      default: occ = '0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/stage_data_reg.sv
// Payload register with async active-high reset, write enable and a synchronous clear
// that takes precedence over the write.
module stage_data_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer; in_ready and out_valid are decoded
// purely from the state flops, so there is no combinational path from out_ready to in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [1:0]       state_q, state_d;
  logic             push, pop;
  logic             main_wen, main_clr, skid_wen, skid_clr, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign occupancy = occ_of(state_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_wen       = 1'b0;
    main_clr       = 1'b0;
    skid_wen       = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // A push accepted this cycle is squashed along with everything held.
      state_d  = ST_EMPTY;
      main_clr = CLR_DATA;
      skid_clr = CLR_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d  = ST_BUSY;
            main_wen = 1'b1;
          end
        end
        ST_BUSY: begin
          if (push && pop) begin
            main_wen = 1'b1;
          end else if (push) begin
            // Main holds still under stall; overflow parks in the skid entry.
            state_d  = ST_FULL;
            skid_wen = 1'b1;
          end else if (pop) begin
            state_d  = ST_EMPTY;
            main_clr = CLR_DATA;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_BUSY;
            main_wen       = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = CLR_DATA;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = CLR_DATA;
          skid_clr = CLR_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  stage_data_reg #(
    .WIDTH(WIDTH)
  ) u_main_reg (
    .clk(clk),
    .rst(rst),
    .wen(main_wen),
    .clr(main_clr),
    .d  (main_d),
    .q  (out_data)
  );

  stage_data_reg #(
    .WIDTH(WIDTH)
  ) u_skid_reg (
    .clk(clk),
    .rst(rst),
    .wen(skid_wen),
    .clr(skid_clr),
    .d  (in_data),
    .q  (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random bench for pipe_stage_skid: a queue model predicts every output of a
// CLR_DATA=1 and a CLR_DATA=0 instance driven by the same stimulus.
`timescale 1ns/1ps
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] q[$];
  logic [15:0] m0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(16), .CLR_DATA(1'b1)) dut_clr (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_skid #(.WIDTH(16), .CLR_DATA(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: drive inputs, check outputs, advance the model to the next edge.
  task automatic cycle(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    logic exp_rdy, exp_vld, ir_before;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = (q.size() < 2);
    exp_vld = (q.size() > 0);
    chk("in_ready",   {in_ready1, in_ready0},   {exp_rdy, exp_rdy});
    chk("out_valid",  {out_valid1, out_valid0}, {exp_vld, exp_vld});
    chk("occupancy",  {occ1, occ0},             {2'(q.size()), 2'(q.size())});
    chk("out_data_clr",  out_data1, exp_vld ? q[0] : 16'h0);
    chk("out_data_keep", out_data0, m0);
    ir_before = in_ready1;
    out_ready = ~ordy;
    #1;
    chk("in_ready_vs_out_ready", in_ready1, ir_before);
    out_ready = ordy;
    #1;
    if (ordy && exp_vld) void'(q.pop_front());
    if (fl) q.delete();
    else if (iv && exp_rdy) q.push_back(id);
    if (q.size() > 0) m0 = q[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m0 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    cycle(0, 16'h0, 0, 0);

    // Stream 0x0001..0x0010 back-to-back with out_ready held high
    for (int i = 1; i <= 16; i++) cycle(1, 16'(i), 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Back-pressure: fill both entries, offer a third that must be refused
    cycle(1, 16'hAAAA, 0, 0);
    cycle(1, 16'hBBBB, 0, 0);
    cycle(1, 16'hDEAD, 0, 0);
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Flush while full with a coincident (refused) push, then while busy with an accepted one
    cycle(1, 16'h1111, 0, 0);
    cycle(1, 16'h2222, 0, 0);
    cycle(1, 16'hCCCC, 0, 1);
    cycle(1, 16'h3333, 0, 0);
    cycle(1, 16'hCCCC, 0, 1);
    cycle(0, 16'h0, 1, 0);
    cycle(1, 16'h4444, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Asynchronous reset mid-stream with two entries held
    cycle(1, 16'h5555, 0, 0);
    cycle(1, 16'h6666, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    chk("rst_in_ready",  {in_ready1, in_ready0},   2'b11);
    chk("rst_occupancy", {occ1, occ0},             4'h0);
    chk("rst_out_data",  {out_data1, out_data0},   32'h0);
    q.delete();
    m0 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 16'h0, 0, 0);

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0));
    end
    repeat (3) cycle(0, 16'h0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
